// File: rtl/ddr_fifo_pkg.sv
// Shared types and constants for the DDR FIFO loopback test sequencer.
// Holds the phase encoding and the pattern wrap point.
package ddr_fifo_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4,
        FAIL   = 3'd5
    } state_e;

    localparam int          DATA_W_DEF   = 32;
    localparam logic [31:0] PATTERN_WRAP = 32'hFFFF_FFFF;

endpackage

// File: rtl/ddr_fifo_test_ctrl.sv
// DDR FIFO loopback sequencer: drives the incrementing write pattern, paces
// fill/stream/drain, and reports pass/fail and word counts to the host.
module ddr_fifo_test_ctrl
    import ddr_fifo_pkg::*;
#(
    parameter int                DATA_W        = DATA_W_DEF,
    parameter int                LEVEL_W       = 16,
    parameter int                FILL_LEVEL    = 1024,
    parameter logic [DATA_W-1:0] RUN_WORDS     = DATA_W'(32'h0010_0000),
    parameter int                DRAIN_TIMEOUT = 4096
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               fifo_full_i,
    input  logic               fifo_empty_i,
    input  logic [LEVEL_W-1:0] fifo_level_i,
    input  logic               rd_data_valid_i,
    input  logic               chk_error_i,
    output logic               wr_en_o,
    output logic [DATA_W-1:0]  wr_data_o,
    output logic               rd_en_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               fail_o,
    output logic [DATA_W-1:0]  wr_cnt_o,
    output logic [DATA_W-1:0]  rd_cnt_o
);

    localparam int                 TMO_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(DRAIN_TIMEOUT - 1);
    localparam logic [LEVEL_W-1:0] FILL_LVL = LEVEL_W'(FILL_LEVEL);
    localparam logic [DATA_W-1:0]  LAST_WR  = RUN_WORDS - 1'b1;
    localparam logic [DATA_W-1:0]  WRAP_VAL = DATA_W'(PATTERN_WRAP);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [DATA_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic [DATA_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               done_q, fail_q;
    logic               run_start;

    // A run may only be (re)launched from a resting phase.
    assign run_start = start_i && (state_q inside {IDLE, DONE, FAIL});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, FAIL: begin
                if (start_i) state_d = FILL;
            end
            FILL: begin
                if (chk_error_i)                  state_d = FAIL;
                else if (stop_i)                  state_d = DRAIN;
                else if (fifo_level_i >= FILL_LVL) state_d = STREAM;
            end
            STREAM: begin
                if (chk_error_i)                                  state_d = FAIL;
                else if (stop_i || (wr_en_o && wr_cnt_q == LAST_WR)) state_d = DRAIN;
            end
            DRAIN: begin
                if (chk_error_i) state_d = FAIL;
                else if (fifo_empty_i && (rd_cnt_q == wr_cnt_q) && !rd_data_valid_i)
                    state_d = DONE;
                else if (tmo_q == TMO_LAST) state_d = FAIL;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are zero-latency from registered phase and the FIFO flags.
    always_comb begin
        wr_en_o = 1'b0;
        rd_en_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            FILL: begin
                wr_en_o = !fifo_full_i;
                busy_o  = 1'b1;
            end
            STREAM: begin
                wr_en_o = !fifo_full_i;
                rd_en_o = !fifo_empty_i;
                busy_o  = 1'b1;
            end
            DRAIN: begin
                rd_en_o = !fifo_empty_i;
                busy_o  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_data_d = wr_data_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        tmo_d     = tmo_q;
        if (run_start) begin
            wr_data_d = '0;
            wr_cnt_d  = '0;
            rd_cnt_d  = '0;
            tmo_d     = '0;
        end else begin
            if (wr_en_o) begin
                wr_data_d = (wr_data_q == WRAP_VAL) ? '0 : wr_data_q + 1'b1;
                wr_cnt_d  = wr_cnt_q + 1'b1;
            end
            if (rd_data_valid_i) rd_cnt_d = rd_cnt_q + 1'b1;
            if (state_q == DRAIN) tmo_d = rd_data_valid_i ? '0 : tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_data_q <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            wr_data_q <= wr_data_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            tmo_q     <= tmo_d;
            done_q    <= (state_d == DONE);
            fail_q    <= (state_d == FAIL);
        end
    end

    assign wr_data_o = wr_data_q;
    assign wr_cnt_o  = wr_cnt_q;
    assign rd_cnt_o  = rd_cnt_q;
    assign done_o    = done_q;
    assign fail_o    = fail_q;

endmodule

// File: tb/tb_ddr_fifo_test_ctrl.sv
// Bench for ddr_fifo_test_ctrl: ideal FIFO (read latency 1) plus a phase-level
// reference model; outputs are compared every cycle away from the clock edge.
module tb_ddr_fifo_test_ctrl;

    localparam int RUN = 2048;
    localparam int FLV = 1024;
    localparam int TMO = 4096;
    localparam int PI = 0, PF = 1, PS = 2, PD = 3, PN = 4, PX = 5;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, fifo_full, fifo_empty, rd_data_valid, chk;
    logic [15:0] fifo_level;
    logic        wr_en_o, rd_en_o, busy_o, done_o, fail_o;
    logic [31:0] wr_data_o, wr_cnt_o, rd_cnt_o;

    always #5 clk = ~clk;

    ddr_fifo_test_ctrl #(
        .DATA_W(32), .LEVEL_W(16), .FILL_LEVEL(FLV),
        .RUN_WORDS(32'(RUN)), .DRAIN_TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
        .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty), .fifo_level_i(fifo_level),
        .rd_data_valid_i(rd_data_valid), .chk_error_i(chk),
        .wr_en_o(wr_en_o), .wr_data_o(wr_data_o), .rd_en_o(rd_en_o), .busy_o(busy_o),
        .done_o(done_o), .fail_o(fail_o), .wr_cnt_o(wr_cnt_o), .rd_cnt_o(rd_cnt_o)
    );

    int          n_tests = 0, n_fail = 0;
    int          ph, m_quiet, fq_n;
    logic [31:0] m_data, m_wcnt, m_rcnt, rd_wcnt;
    bit          rv, k_full_rand, k_full_now, k_stuck, seen_rd;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ph = PI; m_data = 0; m_wcnt = 0; m_rcnt = 0; m_quiet = 0; fq_n = 0; rv = 0;
    endtask

    // One clock cycle: drive FIFO-side inputs, check outputs, advance the model.
    task automatic tick(input string tag);
        bit ew, er, full, empty, rdv, launch;
        int nph;
        full  = k_full_now || (k_full_rand && ph == PS && $urandom_range(0, 1) == 1);
        empty = k_stuck ? 1'b0 : (fq_n == 0);
        rdv   = k_stuck ? 1'b0 : rv;
        fifo_full = full; fifo_empty = empty; fifo_level = 16'(fq_n); rd_data_valid = rdv;
        #1;
        ew = (ph == PF || ph == PS) && !full;
        er = (ph == PS || ph == PD) && !empty;
        check(tag, 128'({wr_en_o, rd_en_o, busy_o, done_o, fail_o, wr_data_o, wr_cnt_o, rd_cnt_o}),
                   128'({ew, er, (ph == PF || ph == PS || ph == PD), (ph == PN), (ph == PX),
                         m_data, m_wcnt, m_rcnt}));
        if (rd_en_o && !seen_rd) begin seen_rd = 1; rd_wcnt = wr_cnt_o; end
        launch = start && (ph == PI || ph == PN || ph == PX);
        nph = ph;
        if (ph == PI || ph == PN || ph == PX) begin
            if (start) nph = PF;
        end else if (chk) nph = PX;
        else if (ph == PF) begin
            if (stop) nph = PD;
            else if (fq_n >= FLV) nph = PS;
        end else if (ph == PS) begin
            if (stop || (ew && m_wcnt == RUN - 1)) nph = PD;
        end else begin
            if (empty && m_rcnt == m_wcnt && !rdv) nph = PN;
            else if (m_quiet == TMO - 1) nph = PX;
        end
        if (launch) begin
            m_data = 0; m_wcnt = 0; m_rcnt = 0; m_quiet = 0;
        end else begin
            if (ew) begin m_data++; m_wcnt++; fq_n++; end
            if (rdv) m_rcnt++;
            if (ph == PD) m_quiet = rdv ? 0 : m_quiet + 1;
        end
        if (er && !k_stuck) fq_n--;
        rv = er && !k_stuck;
        ph = nph;
        @(posedge clk);
        @(negedge clk);
        start = 0; stop = 0; chk = 0; k_full_now = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 0; start = 0; stop = 0; chk = 0;
        fifo_full = 0; fifo_empty = 1; fifo_level = 0; rd_data_valid = 0;
        k_full_rand = 0; k_full_now = 0; k_stuck = 0; seen_rd = 0; rd_wcnt = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_state", 128'({wr_en_o, rd_en_o, busy_o, done_o, fail_o, wr_data_o, wr_cnt_o, rd_cnt_o}), 128'(0));
        rst_n = 1;
        stop = 1;
        tick("idle_stop");

        // Full run: FILL ramp to 1024, STREAM with random full, DRAIN to DONE.
        k_full_rand = 1;
        start = 1;
        tick("start");
        for (int i = 0; i < 20000 && !(ph == PN || ph == PX); i++) tick("run");
        check("first_rd_wcnt", 128'(rd_wcnt), 128'(1025));
        check("run_done", 128'({done_o, fail_o, wr_cnt_o, rd_cnt_o, wr_data_o}),
                          128'({1'b1, 1'b0, 32'(RUN), 32'(RUN), 32'(RUN)}));
        stop = 1;
        tick("done_stop");

        // Pattern wrap through the top of the 32-bit range.
        k_full_rand = 0; fq_n = 0; rv = 0;
        start = 1;
        tick("restart");
        repeat (3) tick("wrap_fill");
        k_full_now = 1;
        force dut.wr_data_q = 32'hFFFF_FFFE;
        m_data = 32'hFFFF_FFFE;
        tick("wrap_force");
        release dut.wr_data_q;
        repeat (4) tick("wrap");
        check("wrap_val", 128'(wr_data_o), 128'(2));
        stop = 1;
        tick("wrap_stop");
        for (int i = 0; i < 5000 && ph == PD; i++) tick("wrap_drain");
        check("wrap_done", 128'({done_o, fail_o}), 128'(2'b10));

        // chk_error together with stop in STREAM wins over DRAIN.
        fq_n = 0; rv = 0;
        start = 1;
        tick("restart2");
        for (int i = 0; i < 3000 && ph == PF; i++) tick("fill2");
        k_full_rand = 1;
        start = 1;
        tick("stream_start");
        repeat (4) tick("stream2");
        chk = 1; stop = 1;
        tick("chk_stop");
        check("fail_now", 128'({fail_o, done_o, wr_en_o, rd_en_o}), 128'(4'b1000));
        stop = 1;
        repeat (3) tick("fail_hold");
        check("fail_held", 128'({fail_o, busy_o}), 128'(2'b10));

        // DRAIN stall: FIFO claims data but never returns it.
        k_full_rand = 0; fq_n = 0; rv = 0;
        start = 1;
        tick("restart3");
        repeat (10) tick("fill3");
        stop = 1;
        tick("fill_stop");
        k_stuck = 1;
        n = 0;
        while (!fail_o && n < 6000) begin tick("drain_stall"); n++; end
        check("tmo_cycles", 128'(n), 128'(TMO));
        k_stuck = 0; fq_n = 0; rv = 0;

        // Asynchronous reset in the middle of FILL.
        start = 1;
        tick("restart4");
        repeat (5) tick("fill4");
        fifo_full = 0; fifo_empty = 1; rd_data_valid = 0;
        #2;
        check("pre_rst_wr_en", 128'(wr_en_o), 128'(1));
        rst_n = 0;
        #1;
        check("async_rst", 128'({wr_en_o, rd_en_o, busy_o, done_o, fail_o, wr_data_o, wr_cnt_o, rd_cnt_o}), 128'(0));
        model_reset();
        @(negedge clk);
        rst_n = 1;
        tick("post_rst");
        start = 1;
        tick("post_rst_start");
        repeat (3) tick("post_rst_fill");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ddr_fifo_test_ctrl.md
Name: ddr_fifo_test_ctrl

Overview:
Sequencer for the DDR FIFO loopback test. It generates the incrementing 32-bit write pattern and paces FIFO writes and reads through fill, stream and drain phases. It sits in front of the FIFO and beside the data-correctness checker. It watches the checker's aggregated error flag and reports pass/fail plus word counts to the host/VIO.

Parameters:
DATA_W, 32, width of test pattern and word counters
LEVEL_W, 16, width of fifo_level
FILL_LEVEL, 1024, FIFO occupancy at which reading starts
RUN_WORDS, 32'h0010_0000, words written before drain begins
DRAIN_TIMEOUT, 4096, cycles without rd_data_valid in DRAIN before fail

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle pulse; starts a run from IDLE, DONE or FAIL
stop  in  1  single-cycle pulse; ends writing early
fifo_full  in  1  FIFO cannot accept a write this cycle
fifo_empty  in  1  FIFO has no word to read this cycle
fifo_level  in  LEVEL_W  current FIFO occupancy
rd_data_valid  in  1  FIFO read data valid (one per read)
chk_error  in  1  OR of the checker's enabled error bits
wr_en  out  1  FIFO write strobe
wr_data  out  DATA_W  write pattern
rd_en  out  1  FIFO read strobe
busy  out  1  high in FILL, STREAM, DRAIN
done  out  1  high in DONE
fail  out  1  high in FAIL
wr_cnt  out  DATA_W  words written this run
rd_cnt  out  DATA_W  words read back this run

Behaviour:
- Reset: state=IDLE. wr_data, wr_cnt, rd_cnt and the timeout counter are 0. wr_en, rd_en, busy, done and fail are 0.
- wr_en = (state is FILL or STREAM) and !fifo_full. This is combinational from registered state and the flag, with zero latency.
- rd_en = (state is STREAM or DRAIN) and !fifo_empty. This is also combinational.
- wr_data is a register. On every cycle with wr_en=1 it increments by 1 at the clock edge and wraps from 32'hFFFF_FFFF to 0. The sequence is 0,1,2,…
- wr_cnt increments on wr_en. rd_cnt increments on rd_data_valid. Both wrap silently.
- IDLE:
  - start → FILL, with wr_data, wr_cnt, rd_cnt and timeout cleared on the same edge.
  - stop is ignored.
- FILL:
  - Writes only.
  - fifo_level >= FILL_LEVEL → STREAM.
  - stop → DRAIN.
  - chk_error → FAIL.
- STREAM:
  - Writes and reads run concurrently.
  - Transition to DRAIN when stop=1, or when wr_cnt==RUN_WORDS-1 and wr_en=1 (last write accepted this cycle). Both conditions together → DRAIN.
- DRAIN:
  - Reads only.
  - The timeout counter clears on rd_data_valid; otherwise it increments.
  - fifo_empty=1, rd_cnt==wr_cnt and no rd_data_valid this cycle → DONE.
  - Timeout counter reaching DRAIN_TIMEOUT-1 → FAIL.
- DONE and FAIL:
  - Both hold until start, which restarts at FILL as from IDLE.
  - stop is ignored.
- chk_error in FILL, STREAM or DRAIN → FAIL next edge. chk_error has priority over every other transition in the same cycle.
- start in FILL, STREAM or DRAIN is ignored.
- done and fail are mutually exclusive and are registered decodes of state.
- Asserting rst mid-run forces IDLE immediately (asynchronous) and zeroes all outputs. wr_en and rd_en drop in the same instant.

Decomposition:
- Shared package ddr_fifo_pkg holds:
  - state enum: IDLE=3'd0, FILL=3'd1, STREAM=3'd2, DRAIN=3'd3, DONE=3'd4, FAIL=3'd5
  - DATA_W default
  - wrap constant 32'hFFFF_FFFF
- No sub-module is needed. Do not split the pattern counter out; it is a single register.

Test Plan:
1. Reset release, start, fifo_full=0, fifo_empty=1, level ramps 0..1024 → wr_en=1 every cycle. wr_data 0..1023 appears. STREAM is entered the cycle after level=1024. No rd_en before that.
2. RUN_WORDS=2048 with an ideal FIFO model (level tracking, read latency 1) → exactly 2048 writes. Last wr_data=2047. DRAIN reads the rest. done=1 with wr_cnt=rd_cnt=2048 and fail=0.
3. fifo_full toggling every other cycle in STREAM → wr_en=0 whenever full. wr_data stays gapless and increments only on accepted writes.
4. Preload wr_data near wrap (force 32'hFFFF_FFFE) → the next writes are FFFF_FFFE, FFFF_FFFF, 0, 1 with no fail.
5. chk_error pulse during STREAM, coinciding with stop → FAIL next edge (not DRAIN). wr_en and rd_en go 0, and fail stays 1 until start.
6. In DRAIN, fifo_empty=0 but rd_data_valid held 0 → fail after DRAIN_TIMEOUT=4096 cycles. rst low mid-FILL → wr_en drops asynchronously, and wr_cnt reads 0.
